// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per operand bit followed by a sign-fixup cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  input  logic             Write_HI,
  input  logic             Write_LO,
  input  logic [WIDTH-1:0] Write_Data,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   orig_a;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   quo_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Unsigned ops (Op[0]=1) never take the magnitude path.
  always_comb begin
    a_neg = ~Op[0] & Operand_A[WIDTH-1];
    b_neg = ~Op[0] & Operand_B[WIDTH-1];
    mag_a = a_neg ? (~Operand_A + 1'b1) : Operand_A;
    mag_b = b_neg ? (~Operand_B + 1'b1) : Operand_B;
  end

  // acc = {partial product, remaining multiplier}; the add carry shifts into the top.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // acc = {remainder, quotient}; the shifted remainder needs one extra bit before the trial subtract.
  always_comb begin
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    quo_sh   = {acc[WIDTH-2:0], 1'b0};
    rem_diff = rem_sh - {1'b0, addend};
    if (rem_sh >= {1'b0, addend})
      div_next = {rem_diff[WIDTH-1:0], quo_sh | {{(WIDTH-1){1'b0}}, 1'b1}};
    else
      div_next = {rem_sh[WIDTH-1:0], quo_sh};
  end

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    quo_fix  = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = sign_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      div_zero    <= 1'b0;
      addend      <= '0;
      orig_a      <= '0;
      acc         <= '0;
      cnt         <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Div_By_Zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            is_div   <= Op[1];
            sign_a   <= a_neg;
            sign_b   <= b_neg;
            orig_a   <= Operand_A;
            div_zero <= (Operand_B == '0);
            cnt      <= '0;
            Busy     <= 1'b1;
            if (Op[1]) begin
              acc    <= {{WIDTH{1'b0}}, mag_a};
              addend <= mag_b;
              state  <= DIV;
            end else begin
              acc    <= {{WIDTH{1'b0}}, mag_b};
              addend <= mag_a;
              state  <= MUL;
            end
          end else begin
            if (Write_HI) HI <= Write_Data;
            if (Write_LO) LO <= Write_Data;
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            HI <= prod_fix[2*WIDTH-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            HI          <= orig_a;
            LO          <= '1;
            Div_By_Zero <= 1'b1;
          end else begin
            HI          <= rem_fix;
            LO          <= quo_fix;
            Div_By_Zero <= 1'b0;
          end
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
